// File: rtl/mem_arbiter.sv
// Two-port request arbiter in front of a single-ported, fixed-latency memory.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default: port 0 priority).

module mem_arbiter_rsp #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [DATA_W-1:0] rdata
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      rdata <= '0;
    end else begin
      valid <= done;
      if (done) rdata <= dout;
    end
  end
endmodule

module mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 4,
  parameter int READ_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  localparam int CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {IDLE, WRITE, WRITE_HOLD, READ_WAIT} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     port;
  logic                     gnt;
  logic                     acc;
  logic [1:0]               valid, we, ready, done, rsp_v;
  logic [1:0][ADDR_W-1:0]   addr;
  logic [1:0][DATA_W-1:0]   wdata, rsp_d;

  assign valid = {req1_valid, req0_valid};
  assign we    = {req1_we,    req0_we};
  assign addr  = {req1_addr,  req0_addr};
  assign wdata = {req1_wdata, req0_wdata};

`ifdef ARB_ROUND_ROBIN_EN
  logic last;  // port granted most recently; reset to 1 so port 0 wins the first tie
`endif

  always_comb begin
    gnt = 1'b0;
    if (valid[1] && !valid[0]) gnt = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    else if (&valid) gnt = ~last;
`endif
  end

  assign ready      = (state == IDLE && !rst) ? (valid & (gnt ? 2'b10 : 2'b01)) : 2'b00;
  assign acc        = |ready;
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      cnt      <= '0;
      port     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (acc) begin
          mem_addr <= addr[gnt];
          mem_din  <= wdata[gnt];
          port     <= gnt;
`ifdef ARB_ROUND_ROBIN_EN
          last     <= gnt;
`endif
          if (we[gnt]) begin
            state  <= WRITE;
            mem_we <= 1'b1;
          end else begin
            state  <= READ_WAIT;
            cnt    <= CNT_W'(READ_LAT);
          end
        end
        WRITE: begin
          state  <= WRITE_HOLD;
          mem_we <= 1'b0;
        end
        WRITE_HOLD: state <= IDLE;
        READ_WAIT: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Last READ_WAIT cycle: mem_dout is valid, capture it for the owning port.
  assign done = (state == READ_WAIT && cnt == '0) ? (port ? 2'b10 : 2'b01) : 2'b00;

  for (genvar p = 0; p < 2; p++) begin : g_rsp
    mem_arbiter_rsp #(.DATA_W(DATA_W)) u_rsp (
      .clk   (clk),
      .rst   (rst),
      .done  (done[p]),
      .dout  (mem_dout),
      .valid (rsp_v[p]),
      .rdata (rsp_d[p])
    );
  end

  assign rsp0_valid = rsp_v[0];
  assign rsp1_valid = rsp_v[1];
  assign rsp0_rdata = rsp_d[0];
  assign rsp1_rdata = rsp_d[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised + directed bench for mem_arbiter: transaction-level model predicts
// grants, memory contents and response timing; a negedge monitor scores the DUT.
module tb_mem_arbiter;
  localparam int AW = 12, DW = 4, RL = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic          req_valid [2], req_we [2], req_ready [2], rsp_valid [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2], rsp_rdata [2];
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_we(req_we[0]),
    .req0_addr(req_addr[0]), .req0_wdata(req_wdata[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_we(req_we[1]),
    .req1_addr(req_addr[1]), .req1_wdata(req_wdata[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_rdata(rsp_rdata[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_rdata(rsp_rdata[1]),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // External memory: data appears RL edges after the address is presented.
  logic [DW-1:0] dev_mem [0:(1<<AW)-1];
  logic [DW-1:0] pipe [RL];
  always @(posedge clk) begin
    if (mem_we) dev_mem[mem_addr] <= mem_din;
    pipe[0] <= dev_mem[mem_addr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_dout = pipe[RL-1];

  // Reference model state
  typedef struct { int port; logic [DW-1:0] data; int cyc; } rsp_t;
  rsp_t          q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_rdata [2];
  int   cyc = 0, free_at = 0, we_cyc = -1, last = 1, cur_addr = 0, acc_cyc = 0;
  int   checks = 0, failures = 0;
  bit   armed = 0, rst_seen = 0;
  bit   acc [2];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit idle, ev;
    int g;
    if (armed) begin
      for (int p = 0; p < 2; p++) begin
        ev = q.size() > 0 && q[0].cyc == cyc && q[0].port == p;
        if (ev) exp_rdata[p] = q[0].data;
        chk($sformatf("rsp%0d_valid", p), 32'(rsp_valid[p]), 32'(ev));
        chk($sformatf("rsp%0d_rdata", p), 32'(rsp_rdata[p]), 32'(exp_rdata[p]));
      end
      if (q.size() > 0 && q[0].cyc <= cyc) void'(q.pop_front());
      chk("mem_we", 32'(mem_we), 32'(cyc == we_cyc));
      if (rst_seen) begin
        chk("mem_addr_rst", 32'(mem_addr), 0);
        chk("mem_din_rst", 32'(mem_din), 0);
        rst_seen = 0;
      end else if (cyc > acc_cyc && cyc < free_at)
        chk("mem_addr_hold", 32'(mem_addr), cur_addr);
    end
    idle = armed && !rst && cyc >= free_at;
    g = 0;
    if (req_valid[1] && !req_valid[0]) g = 1;
`ifdef ARB_ROUND_ROBIN_EN
    else if (req_valid[0] && req_valid[1]) g = 1 - last;
`endif
    if (armed)
      for (int p = 0; p < 2; p++)
        chk($sformatf("req%0d_ready", p), 32'(req_ready[p]),
            32'(idle && req_valid[p] && g == p));
    if (idle && (req_valid[0] || req_valid[1])) begin
      acc[g]   = 1;
      last     = g;
      acc_cyc  = cyc;
      cur_addr = int'(req_addr[g]);
      if (req_we[g]) begin
        ref_mem[req_addr[g]] = req_wdata[g];
        we_cyc  = cyc + 1;
        free_at = cyc + 3;
      end else begin
        q.push_back('{port: g, data: ref_mem[req_addr[g]], cyc: cyc + RL + 2});
        free_at = cyc + RL + 2;
      end
    end
    if (rst) begin
      q.delete();
      free_at = cyc + 1;
      last = 1;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      we_cyc = -1;
      armed = 1;
      rst_seen = 1;
    end
  end

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input int p, input bit w, input int a, input int d);
    int n = 0;
    req_valid[p] = 1; req_we[p] = w; req_addr[p] = AW'(a); req_wdata[p] = DW'(d);
    do begin @(posedge clk); #1; n++; end while (!acc[p] && n < 200);
    if (!acc[p]) begin
      checks++; failures++;
      $display("FAIL accept_timeout port=%0d actual=none required=accept", p);
    end
    acc[p] = 0;
    req_valid[p] = 0;
  endtask

  function automatic int rand_addr();
    int sel = $urandom_range(0, 7);
    case (sel)
      0: return 0;
      1: return 'hFFF;
      2: return 'h3FF;
      3: return 'h400;
      4: return 'hBFF;
      5: return 'hC00;
      6: return $urandom_range(0, 15);
      default: return $urandom_range(0, (1 << AW) - 1);
    endcase
  endfunction

  task automatic rand_traffic(input int p, input int n);
    repeat (n) begin
      gap($urandom_range(0, 3));
      issue(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom_range(0, 15));
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) begin dev_mem[i] = '0; ref_mem[i] = '0; end
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 0; req_we[p] = 0; req_addr[p] = '0; req_wdata[p] = '0; acc[p] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    gap(1);
    // write then read back on port 0
    issue(0, 1, 'h005, 'hA);
    issue(0, 0, 'h005, 0);
    // bank boundaries
    issue(0, 1, 'h3FF, 1); issue(0, 1, 'h400, 2);
    issue(0, 1, 'hBFF, 3); issue(0, 1, 'hC00, 4);
    issue(1, 0, 'h3FF, 0); issue(1, 0, 'h400, 0);
    issue(1, 0, 'hBFF, 0); issue(1, 0, 'hC00, 0);
    // top address does not alias address 0
    issue(0, 1, 'hFFF, 'hF);
    issue(1, 0, 'hFFF, 0);
    issue(1, 0, 'h000, 0);
    // port 1 arrives while port 0 read is in flight
    fork
      issue(0, 0, 'h005, 0);
      begin gap(2); issue(1, 0, 'h400, 0); end
    join
    // continuous tie on reads
    fork
      repeat (4) issue(0, 0, rand_addr(), 0);
      repeat (4) issue(1, 0, rand_addr(), 0);
    join
    // reset two cycles into a read
    issue(0, 0, 'hFFF, 0);
    gap(1);
    rst = 1;
    gap(1);
    rst = 0;
    gap(2);
    // random mixed traffic on both ports
    fork
      rand_traffic(0, 40);
      rand_traffic(1, 40);
    join
    n = 0;
    while ((q.size() > 0 || cyc < free_at) && n < 100) begin gap(1); n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=pending required=empty");
    end
    gap(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 12, memory address width; DATA_W, default 4, data width; READ_LAT, default 3, clock edges from mem_addr first driven to valid mem_dout.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on posedge.
REQ-003 SHALL have ports: rst  in  1  synchronous reset, active-high.
REQ-004 SHALL have ports, N in {0,1}: reqN_valid in 1; reqN_ready out 1; reqN_we in 1 (1=write, 0=read); reqN_addr in ADDR_W; reqN_wdata in DATA_W.
REQ-005 SHALL have ports, N in {0,1}: rspN_valid out 1, one-cycle read-data pulse; rspN_rdata out DATA_W.
REQ-006 SHALL have ports: mem_we out 1; mem_addr out ADDR_W; mem_din out DATA_W; mem_dout in DATA_W; these connect to the banked 4K x 4 memory.

Function
REQ-007 SHALL implement FSM states IDLE, WRITE, WRITE_HOLD, READ_WAIT.
REQ-008 SHALL assert reqN_ready only in IDLE, combinationally, for the single granted port with reqN_valid=1; ready is never asserted to both ports in one cycle.
REQ-009 SHALL transfer a request on the edge where reqN_valid and reqN_ready are both 1 (cycle T); requester holds fields stable until then.
REQ-010 SHALL register the accepted addr/wdata into mem_addr/mem_din at end of T; both stay constant until the FSM next returns to IDLE.
REQ-011 Write: SHALL go IDLE->WRITE (T+1, mem_we=1)->WRITE_HOLD (T+2, mem_we=0)->IDLE (T+3); writes produce no response.
REQ-012 Read: SHALL go IDLE->READ_WAIT, mem_we=0, for READ_LAT+1 cycles (T+1..T+READ_LAT+1), counted with a down-counter.
REQ-013 SHALL capture mem_dout into rspN_rdata at the end of cycle T+READ_LAT+1 and pulse rspN_valid for the accepting port in cycle T+READ_LAT+2, together with the return to IDLE.
REQ-014 SHALL allow a new acceptance in the IDLE cycle that carries rspN_valid (back-to-back reads every READ_LAT+2 cycles; writes every 3 cycles).
REQ-015 rspN_rdata SHALL hold its last value until the next read for port N completes.
REQ-016 mem_we SHALL be 0 in every state except WRITE.
REQ-017 When exactly one port is valid in IDLE, that port SHALL be granted regardless of priority.
REQ-018 Arbitration is evaluated only in IDLE; requests arriving during WRITE/WRITE_HOLD/READ_WAIT SHALL wait, with no loss of request.
REQ-019 Address arithmetic SHALL be full ADDR_W width with no range check; addresses 0 and 2^ADDR_W-1 are legal.

Reset
REQ-020 On rst=1 at a clock edge SHALL force IDLE, mem_we=0, mem_addr=0, mem_din=0, rsp0_valid=rsp1_valid=0, rsp0_rdata=rsp1_rdata=0, counter=0, last-grant pointer=1 (port 0 wins first tie).
REQ-021 Reset asserted mid-operation SHALL abort it; a pending read response is discarded and never pulsed.
REQ-022 reqN_ready SHALL be 0 in any cycle where rst=1.

Configuration
REQ-023 With macro ARB_ROUND_ROBIN_EN defined, SHALL break ties with round-robin: the port not granted most recently wins, and the pointer updates on every acceptance.
REQ-024 Without ARB_ROUND_ROBIN_EN, SHALL use fixed priority: port 0 always wins ties, and the pointer logic is absent.

Verification
REQ-025 Write: port0 writes addr 0x005 data 0xA, then reads 0x005 -> mem_we high exactly one cycle; rsp0_valid at acceptance+READ_LAT+2 with rsp0_rdata=0xA.
REQ-026 Bank boundary: writes 0x3FF=1, 0x400=2, 0xBFF=3, 0xC00=4, then reads each -> returns 1, 2, 3, 4 in order on the requesting port.
REQ-027 Tie with ARB_ROUND_ROBIN_EN: both ports hold read requests continuously -> grants alternate 0,1,0,1, spaced 5 cycles apart (READ_LAT=3); without the macro -> port 1 is never granted while port 0 stays valid.
REQ-028 Hold-off: port1 asserts valid during port0's READ_WAIT -> reqN_ready=0 until IDLE, then port1 is accepted in the response cycle; mem_addr stays stable throughout READ_WAIT.
REQ-029 Reset mid-read: rst pulsed at T+2 of a read -> no rspN_valid, FSM in IDLE, all outputs at reset values next cycle.
REQ-030 Max address: write 0xFFF=0xF, then read -> rdata 0xF, no wrap to address 0.
